// File: rtl/pisa_pkg.sv
// Shared PISA definitions: default widths, the HALT encoding and the fetch FSM states.
package pisa_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 20;
  localparam int unsigned ADDRESS_WIDTH_DEF = 8;
  localparam int unsigned MEM_SIZE_DEF      = 256;

  localparam logic [DATA_WIDTH_DEF-1:0] HALT_INSTR_DEF = 20'hFFFFF;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_HALT  = 2'd1,
    FS_FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: squash clears valid, hold freezes everything, load captures a new fetch.
module if_id_reg
  import pisa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hold,
  input  logic                     squash,
  input  logic                     load,
  input  logic [DATA_WIDTH-1:0]    instr_in,
  input  logic [ADDRESS_WIDTH-1:0] pc_in,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     valid
);

  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     valid_q, valid_d;

  // Squash only drops valid; the stale instr/pc are kept so a debugger still sees the last fetch.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (squash) begin
      valid_d = 1'b0;
    end else if (!hold && load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// PISA instruction fetch: PC register, next-PC mux, RUN/HALT/FAULT FSM and the IF/ID register.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage
  import pisa_pkg::*;
#(
  parameter int unsigned                DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned                ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned                MEM_SIZE      = MEM_SIZE_DEF,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]      HALT_INSTR    = HALT_INSTR_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  output logic [DATA_WIDTH-1:0]    if_id_instr,
  output logic [ADDRESS_WIDTH-1:0] if_id_pc,
  output logic                     if_id_valid,
  output logic                     halted,
  output logic                     fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              perf_fetch_cnt,
  output logic [31:0]              perf_stall_cnt
`endif
);

  // One extra bit so MEM_SIZE == 2^ADDRESS_WIDTH is representable and never faults.
  localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT = (ADDRESS_WIDTH+1)'(MEM_SIZE);

  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic                     ifid_hold, ifid_squash, ifid_load;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_hold   = 1'b0;
    ifid_squash = 1'b0;
    ifid_load   = 1'b0;
    if (redirect) begin
      pc_d        = redirect_pc;
      state_d     = FS_RUN;
      ifid_squash = 1'b1;
    end else if (stall) begin
      ifid_hold = 1'b1;
    end else begin
      unique case (state_q)
        FS_RUN: begin
          if ({1'b0, pc_q} >= MEM_LIMIT) begin
            state_d     = FS_FAULT;
            ifid_squash = 1'b1;
          end else begin
            ifid_load = 1'b1;
            if (imem_instr == HALT_INSTR) begin
              state_d = FS_HALT;
            end else begin
              pc_d = pc_q + ADDRESS_WIDTH'(1);
            end
          end
        end
        default: ifid_squash = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (ifid_hold),
    .squash   (ifid_squash),
    .load     (ifid_load),
    .instr_in (imem_instr),
    .pc_in    (pc_q),
    .instr    (if_id_instr),
    .pc       (if_id_pc),
    .valid    (if_id_valid)
  );

  assign imem_addr = pc_q;
  assign halted    = (state_q == FS_HALT);
  assign fault     = (state_q == FS_FAULT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // ifid_load is only raised on edges that actually write a valid instruction into IF/ID.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (ifid_load)          fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall && !redirect) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the PISA pipeline. It owns the program counter, drives the instruction memory's combinational read address, and registers the returned 20-bit instruction and its PC into the IF/ID pipeline register. It handles stalls from the hazard unit and branch/jump redirects from later stages, and stops fetching after a HALT instruction.

## Interface
- `DATA_WIDTH`, 20: instruction width.
- `ADDRESS_WIDTH`, 8: PC and instruction-address width.
- `MEM_SIZE`, 256: number of valid instruction words. Must be ≤ 2^ADDRESS_WIDTH.
- `RESET_PC`, 0: PC value loaded at reset.
- `HALT_INSTR`, 20'hFFFFF: full-word encoding of the HALT instruction.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hazard unit. Holds the PC and IF/ID contents.
- `redirect` in 1: taken branch or jump from a later stage.
- `redirect_pc` in ADDRESS_WIDTH: target PC for a redirect.
- `imem_addr` out ADDRESS_WIDTH: read address to the instruction memory. Equals `pc`.
- `imem_instr` in DATA_WIDTH: combinational read data from the instruction memory.
- `if_id_instr` out DATA_WIDTH: registered instruction.
- `if_id_pc` out ADDRESS_WIDTH: PC of `if_id_instr`.
- `if_id_valid` out 1: IF/ID holds a real instruction (0 = bubble).
- `halted` out 1: stage is in HALT.
- `fault` out 1: stage is in FAULT (PC out of range).

## Operation
- **States:** RUN, HALT, FAULT. FSM state and every output are reset asynchronously.
- **Reset values:**
  - State = RUN, `pc` = RESET_PC.
  - `if_id_instr` = 0, `if_id_pc` = 0, `if_id_valid` = 0.
  - `halted` = 0, `fault` = 0.
- **Per-cycle priority:** `redirect` > `stall` > FSM action.
- **Redirect** (any state):
  - `pc` ← `redirect_pc`, state ← RUN.
  - `if_id_valid` ← 0 (squash). `if_id_instr` and `if_id_pc` hold.
  - Redirect wins over a simultaneous stall.
- **Stall** (no redirect): `pc`, IF/ID, and state all hold.
- **RUN, no stall, no redirect:**
  - If `pc` ≥ MEM_SIZE: state ← FAULT, `if_id_valid` ← 0, `pc` holds.
  - Otherwise, load IF/ID with `imem_instr`, `pc`, valid = 1.
  - If `imem_instr` == HALT_INSTR: state ← HALT, `pc` holds.
  - Otherwise `pc` ← `pc` + 1, modulo 2^ADDRESS_WIDTH (255 → 0).
- **HALT / FAULT, no redirect:**
  - `pc` holds and `if_id_valid` ← 0 every cycle.
  - Only a redirect or reset leaves these states.
  - A HALT fetched on a wrong path is therefore cancelled by the branch that resolves later.
- `halted` = (state == HALT). `fault` = (state == FAULT). Both are registered state decodes.

## Timing
- `imem_addr` is combinational from the `pc` register. The instruction memory returns data in the same cycle.
- Fetch latency is 1 cycle: an instruction at PC p enters IF/ID on the edge ending the cycle in which `pc` = p.
- The HALT instruction itself reaches IF/ID with valid = 1. `halted` rises on the same edge.
- Redirect costs 1 bubble: the target appears in IF/ID two edges after `redirect` is sampled.
- Reset mid-operation returns all state to reset values immediately, with no dependence on `clk`.
- Throughput in RUN without stalls is one instruction per cycle.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- **Defined:** adds outputs `perf_fetch_cnt` and `perf_stall_cnt`, each 32 bits.
  - `perf_fetch_cnt` increments on every edge that loads IF/ID with valid = 1.
  - `perf_stall_cnt` increments on every edge with `stall` = 1 and `redirect` = 0.
  - Both reset asynchronously to 0 and wrap at 2^32.
- **Undefined:** the ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `pisa_pkg` holds:
  - the `fetch_state_t` enum (RUN, HALT, FAULT);
  - the `HALT_INSTR` default;
  - the default width constants.
- One sub-module, `if_id_reg`: the pipeline register with hold (stall), squash (clear valid) and load controls.
- PC register, next-PC mux and FSM live in `fetch_stage`.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run with `pc` = 0x2A. Immediately `pc` = 0, `if_id_valid` = 0, `halted` = 0, with no clock edge needed.
- **Sequential fetch:** memory words 0x00001, 0x00002, 0x00003. Expect IF/ID (pc, instr) = (0, 0x00001), (1, 0x00002), (2, 0x00003) on consecutive edges, valid = 1.
- **Stall then redirect:**
  - Stall 3 cycles at `pc` = 5: `pc` and IF/ID frozen.
  - Assert `redirect` = 1 with `redirect_pc` = 0x40 together with `stall`: next edge `pc` = 0x40, valid = 0.
  - Following edge: IF/ID pc = 0x40.
- **HALT:** HALT_INSTR at address 3.
  - IF/ID gets (3, 0xFFFFF) with valid = 1, and `halted` = 1.
  - Afterwards `pc` stays 3 and valid = 0.
  - Redirect to 0x10 returns to RUN.
- **Wrap / fault:**
  - MEM_SIZE = 256, start at `pc` = 0xFF: next `pc` = 0x00.
  - MEM_SIZE = 16 with `pc` reaching 0x10: `fault` = 1, valid = 0, `pc` held at 0x10.
- **Counters** (`FETCH_PERF_CNT_EN` defined): 10 fetches and 4 stall cycles → `perf_fetch_cnt` = 10, `perf_stall_cnt` = 4.
